// File: rtl/piso_buffer_pkg.sv
// Shared definitions for the parallel-in / serial-out slot buffer.
package piso_pkg;

  localparam int MAX_LENGTH = 16;

  // Wide enough to index any legal slot count.
  typedef logic [$clog2(MAX_LENGTH)-1:0] slot_idx_t;

  // Increment a slot index with an explicit wrap at len-1, so slot counts
  // that are not a power of two rotate correctly.
  function automatic int rr_next(input int idx, input int len);
    return (idx + 1 >= len) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/piso_buffer_rr_arbiter.sv
// Combinational rotating-priority search: returns the first requesting
// index at or after ptr, wrapping past LENGTH-1 back to 0.
module rr_arbiter #(
  parameter int LENGTH = 4,
  parameter int IW     = $clog2(LENGTH)
) (
  input  logic [LENGTH-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [IW-1:0]     grant_idx,
  output logic              grant_valid
);

  // Scan from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_idx   = ptr;
    grant_valid = 1'b0;
    for (int k = LENGTH - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= LENGTH) idx = idx - LENGTH;
      if (req[idx[IW-1:0]]) begin
        grant_idx   = idx[IW-1:0];
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/piso_buffer.sv
// LENGTH single-entry slots, each written by its own producer, drained one
// per cycle in round-robin order through a valid/ready output.
module piso_buffer
  import piso_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int LENGTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           d_in [LENGTH],
  input  logic [LENGTH-1:0]          we,
  output logic [LENGTH-1:0]          used_pos,
  output logic [WIDTH-1:0]           d_out,
  output logic [$clog2(LENGTH)-1:0]  d_out_slot,
  output logic                       d_out_valid,
  input  logic                       d_out_ready,
  output logic [LENGTH-1:0]          overflow
);

  localparam int IW = $clog2(LENGTH);

  logic [WIDTH-1:0]  r_data [LENGTH];
  logic [LENGTH-1:0] r_used;
  logic [LENGTH-1:0] r_overflow;
  logic [IW-1:0]     r_ptr;
  logic              r_lock;
  logic [IW-1:0]     r_lock_idx;

  logic [IW-1:0]     w_grant_idx;
  logic              w_grant_valid;
  logic [IW-1:0]     w_sel;
  logic              w_pop;
  logic [LENGTH-1:0] w_pop_mask;
  logic [LENGTH-1:0] w_accept;

  rr_arbiter #(.LENGTH(LENGTH), .IW(IW)) u_arb (
    .req         (r_used),
    .ptr         (r_ptr),
    .grant_idx   (w_grant_idx),
    .grant_valid (w_grant_valid)
  );

  // A presented-but-unaccepted selection is frozen until it is popped, so a
  // newly filled slot earlier in the rotation cannot change d_out under a
  // stalled consumer.
  assign w_sel = r_lock ? r_lock_idx : w_grant_idx;
  assign w_pop = w_grant_valid & d_out_ready;

  // One-hot of the slot being drained this edge.
  always_comb begin
    w_pop_mask = '0;
    if (w_pop) w_pop_mask[w_sel] = 1'b1;
  end

  // A slot accepts a write when empty or when it is being drained this edge.
  assign w_accept = ~r_used | w_pop_mask;

  // Slot data, occupancy and dropped-write pulses; a write beats a pop clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LENGTH; i++) r_data[i] <= '0;
      r_used     <= '0;
      r_overflow <= '0;
    end else begin
      for (int i = 0; i < LENGTH; i++) begin
        if (we[i] && w_accept[i]) r_data[i] <= d_in[i];
      end
      r_used     <= (r_used & ~w_pop_mask) | we;
      r_overflow <= we & ~w_accept;
    end
  end

  // Round-robin pointer advances past the drained slot; the selection lock
  // is taken on a stalled valid and released by the pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_pop) begin
      r_ptr  <= IW'(rr_next(int'(w_sel), LENGTH));
      r_lock <= 1'b0;
    end else if (w_grant_valid) begin
      r_lock     <= 1'b1;
      r_lock_idx <= w_sel;
    end
  end

  assign used_pos    = r_used;
  assign overflow    = r_overflow;
  assign d_out       = r_data[w_sel];
  assign d_out_slot  = w_sel;
  assign d_out_valid = w_grant_valid;

endmodule

// File: tb/tb_piso_buffer.sv
// Scoreboard bench for piso_buffer: stimulus steps a slot-level reference
// model and queues expected status and transfers; a monitor compares them.
module tb_piso_buffer;

  localparam int W = 32;
  localparam int L = 4;

  logic          clk, clk_en, rst;
  logic [W-1:0]  d_in [L];
  logic [L-1:0]  we;
  logic [L-1:0]  used_pos;
  logic [W-1:0]  d_out;
  logic [1:0]    d_out_slot;
  logic          d_out_valid;
  logic          d_out_ready;
  logic [L-1:0]  overflow;

  piso_buffer #(.WIDTH(W), .LENGTH(L)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .we(we), .used_pos(used_pos),
    .d_out(d_out), .d_out_slot(d_out_slot), .d_out_valid(d_out_valid),
    .d_out_ready(d_out_ready), .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  typedef struct {
    logic         v;
    int           slot;
    logic [W-1:0] data;
    logic [L-1:0] used;
    logic [L-1:0] ovf;
  } stat_t;

  typedef struct {
    int           slot;
    logic [W-1:0] data;
  } xfer_t;

  stat_t sq[$];
  xfer_t xq[$];

  int errors = 0;
  int checks = 0;

  // Reference model: occupancy/data per slot, rotation start, and whether
  // the previous cycle presented a valid output that was not taken.
  bit           m_occ  [L];
  logic [W-1:0] m_data [L];
  int           m_ptr;
  bit           m_hold;
  int           m_prev;
  logic [L-1:0] m_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < L; i++) begin
      m_occ[i]  = 0;
      m_data[i] = '0;
    end
    m_ptr  = 0;
    m_hold = 0;
    m_prev = 0;
    m_ovf  = '0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_used"},  64'(used_pos),    64'(0));
    chk({tag, "_valid"}, 64'(d_out_valid), 64'(0));
    chk({tag, "_dout"},  64'(d_out),       64'(0));
    chk({tag, "_slot"},  64'(d_out_slot),  64'(0));
    chk({tag, "_ovf"},   64'(overflow),    64'(0));
  endtask

  // One clock cycle: drive inputs, record what the DUT must show during the
  // cycle, then advance the model by the rules of the next edge.
  task automatic cycle(input logic [L-1:0] w, input logic r);
    stat_t st;
    xfer_t xf;
    bit    valid, pop, found;
    int    sel;
    @(negedge clk);
    we          = w;
    d_out_ready = r;
    valid = 0;
    for (int i = 0; i < L; i++) if (m_occ[i]) valid = 1;
    if (m_hold) sel = m_prev;
    else begin
      sel   = m_ptr;
      found = 0;
      for (int k = 0; k < L; k++) begin
        if (!found && m_occ[(m_ptr + k) % L]) begin
          sel   = (m_ptr + k) % L;
          found = 1;
        end
      end
    end
    st.v    = valid;
    st.slot = sel;
    st.data = m_data[sel];
    for (int i = 0; i < L; i++) st.used[i] = m_occ[i];
    st.ovf  = m_ovf;
    sq.push_back(st);
    pop = valid && r;
    if (pop) begin
      xf.slot = sel;
      xf.data = m_data[sel];
      xq.push_back(xf);
      m_occ[sel] = 0;
      m_ptr      = (sel + 1) % L;
    end
    for (int i = 0; i < L; i++) begin
      m_ovf[i] = 1'b0;
      if (w[i]) begin
        if (!m_occ[i]) begin
          m_occ[i]  = 1;
          m_data[i] = d_in[i];
        end else m_ovf[i] = 1'b1;
      end
    end
    m_hold = valid && !r;
    m_prev = sel;
    @(posedge clk);
    #1;
    we = '0;
  endtask

  // Monitor: compare per-cycle status, and every accepted transfer.
  initial begin
    stat_t st;
    xfer_t xf;
    forever begin
      @(negedge clk);
      #2;
      if (sq.size() > 0) begin
        st = sq.pop_front();
        chk("mon_valid", 64'(d_out_valid), 64'(st.v));
        chk("mon_slot",  64'(d_out_slot),  64'(st.slot));
        chk("mon_dout",  64'(d_out),       64'(st.data));
        chk("mon_used",  64'(used_pos),    64'(st.used));
        chk("mon_ovf",   64'(overflow),    64'(st.ovf));
      end
      if (d_out_valid === 1'b1 && d_out_ready === 1'b1) begin
        if (xq.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL xfer_unexpected actual=slot%0d/%0h required=none", d_out_slot, d_out);
        end else begin
          xf = xq.pop_front();
          chk("xfer_slot", 64'(d_out_slot), 64'(xf.slot));
          chk("xfer_data", 64'(d_out),      64'(xf.data));
        end
      end
    end
  end

  initial begin
    clk_en      = 1'b0;
    rst         = 1'b0;
    we          = '0;
    d_out_ready = 1'b0;
    for (int i = 0; i < L; i++) d_in[i] = '0;
    model_reset();

    // Reset with no clock running.
    #2 rst = 1'b1;
    #1 reset_checks("rst_noclk");
    #5 rst = 1'b0;
    #5 clk_en = 1'b1;

    // Two simultaneous writes with the consumer stalled.
    d_in[1] = 32'hA1;
    d_in[3] = 32'hA3;
    cycle(4'b1010, 1'b0);
    chk("t2_valid", 64'(d_out_valid), 64'(1));
    chk("t2_slot",  64'(d_out_slot),  64'(1));
    chk("t2_dout",  64'(d_out),       64'hA1);
    d_in[0] = 32'hA0;
    cycle(4'b0001, 1'b0);
    for (int n = 0; n < 3; n++) begin
      chk("t2_hold_slot", 64'(d_out_slot), 64'(1));
      chk("t2_hold_dout", 64'(d_out),      64'hA1);
      if (n < 2) cycle(4'b0000, 1'b0);
    end

    // Drain in rotation order starting after slot 1.
    cycle(4'b0000, 1'b1);
    chk("t3_pop2_slot", 64'(d_out_slot), 64'(3));
    chk("t3_pop2_dout", 64'(d_out),      64'hA3);
    cycle(4'b0000, 1'b1);
    chk("t3_pop3_slot", 64'(d_out_slot), 64'(0));
    chk("t3_pop3_dout", 64'(d_out),      64'hA0);
    cycle(4'b0000, 1'b1);
    chk("t3_empty_valid", 64'(d_out_valid), 64'(0));
    chk("t3_empty_ptr",   64'(d_out_slot),  64'(1));

    // Asynchronous reset mid-operation, away from any clock edge.
    d_in[2] = 32'h77;
    cycle(4'b0100, 1'b0);
    rst = 1'b1;
    #1 reset_checks("rst_mid");
    model_reset();
    #1 rst = 1'b0;

    // Fairness with every slot refilled every cycle.
    for (int i = 0; i < L; i++) d_in[i] = $urandom;
    cycle(4'b1111, 1'b1);
    for (int k = 0; k < 10; k++) begin
      chk("t4_rr_slot", 64'(d_out_slot), 64'(k % 4));
      for (int i = 0; i < L; i++) d_in[i] = $urandom;
      cycle(4'b1111, 1'b1);
    end
    repeat (4) cycle(4'b0000, 1'b1);
    chk("t4_drained", 64'(d_out_valid), 64'(0));

    // Dropped write to an occupied, stalled slot.
    d_in[2] = 32'h55;
    cycle(4'b0100, 1'b0);
    d_in[2] = 32'hBB;
    cycle(4'b0100, 1'b0);
    chk("t5_ovf",  64'(overflow), 64'(4'b0100));
    chk("t5_dout", 64'(d_out),    64'h55);
    cycle(4'b0000, 1'b0);
    chk("t5_ovf_clear", 64'(overflow), 64'(0));

    // Write to the slot being popped is accepted.
    cycle(4'b0100, 1'b1);
    chk("t6_ovf",   64'(overflow),    64'(0));
    chk("t6_used2", 64'(used_pos[2]), 64'(1));
    chk("t6_dout",  64'(d_out),       64'hBB);
    cycle(4'b0000, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < L; i++) d_in[i] = $urandom;
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 6));
    end
    repeat (8) cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b0);
    @(negedge clk);
    #3;
    chk("final_valid",   64'(d_out_valid), 64'(0));
    chk("xfer_q_empty",  64'(xq.size()),   64'(0));
    chk("stat_q_empty",  64'(sq.size()),   64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
